// File: rtl/clk_pkg.sv
// Shared constants and types for the clock-enable generator.
// The optional level outputs are controlled by the CLK_EN_LEVEL_OUT_EN macro in the design files.
package clk_pkg;

  localparam int          CLK_CNT_W     = 16;
  localparam int          CLK_N_TAPS    = 8;
  localparam int unsigned CLK_DIV_RESET = 1;

  typedef logic [CLK_CNT_W-1:0] clk_div_t;

  typedef enum logic [1:0] {
    ST_STOPPED     = 2'd0,
    ST_RUNNING     = 2'd1,
    ST_RUN_PENDING = 2'd2
  } clk_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Power-of-two sub-rate strobes derived from the base tick.
// Optional square-wave level outputs are built when CLK_EN_LEVEL_OUT_EN is defined.
module tick_prescaler
  import clk_pkg::*;
#(
  parameter int N_TAPS = CLK_N_TAPS
) (
  input  logic              cin,
  input  logic              reset,
  input  logic              tick_en,
`ifdef CLK_EN_LEVEL_OUT_EN
  output logic [N_TAPS-1:0] tap_lvl,
`endif
  output logic [N_TAPS-1:0] tap_stb
);

  logic [N_TAPS-1:0] r_pre;
  logic [N_TAPS-1:0] r_tap_stb;
  logic [N_TAPS-1:0] w_stb_nxt;
  logic              w_ones;

  // Bit k fires when pre[k:0] is all ones; a running AND gives every prefix.
  always_comb begin
    w_stb_nxt = '0;
    w_ones    = 1'b1;
    for (int k = 0; k < N_TAPS; k++) begin
      w_ones       = w_ones & r_pre[k];
      w_stb_nxt[k] = tick_en & w_ones;
    end
  end

  always_ff @(posedge cin) begin
    if (reset) begin
      r_pre     <= '0;
      r_tap_stb <= '0;
    end else begin
      r_tap_stb <= w_stb_nxt;
      if (tick_en) begin
        r_pre <= r_pre + N_TAPS'(1);
      end
    end
  end

  assign tap_stb = r_tap_stb;

`ifdef CLK_EN_LEVEL_OUT_EN
  logic [N_TAPS-1:0] r_tap_lvl;

  always_ff @(posedge cin) begin
    if (reset) begin
      r_tap_lvl <= '0;
    end else begin
      r_tap_lvl <= r_tap_lvl ^ w_stb_nxt;
    end
  end

  assign tap_lvl = r_tap_lvl;
`endif

endmodule

// File: rtl/clk_enable_gen.sv
// Programmable base-rate tick generator with divisor load handshake and sub-rate strobes.
// Defining CLK_EN_LEVEL_OUT_EN adds the tap_lvl square-wave outputs.
module clk_enable_gen
  import clk_pkg::*;
#(
  parameter int          CNT_W     = CLK_CNT_W,
  parameter int          N_TAPS    = CLK_N_TAPS,
  parameter int unsigned DIV_RESET = CLK_DIV_RESET
) (
  input  logic              cin,
  input  logic              reset,
  input  logic              run,
  input  logic              div_load,
  input  logic [CNT_W-1:0]  div_value,
  output logic              div_ready,
  output logic              tick,
  output logic [N_TAPS-1:0] tap_stb,
`ifdef CLK_EN_LEVEL_OUT_EN
  output logic [N_TAPS-1:0] tap_lvl,
`endif
  output logic [1:0]        o_dbg_state
);

  localparam logic [CNT_W-1:0] L_DIV_RESET = CNT_W'(DIV_RESET);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_reg;
  logic [CNT_W-1:0] r_pend_val;
  logic             r_pend;
  logic             r_tick;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] w_pend_val_nxt;
  logic             w_pend_nxt;
  logic             w_tick_nxt;
  logic             w_accept;
  logic             w_cnt_zero;
  clk_state_e       w_state;

  // Handshake: div_value is taken on any edge with div_load && div_ready; div_ready is
  // low only while a divisor is parked in pend_val waiting for the next reload.
  assign w_accept   = div_load & ~r_pend;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    if (!run) begin
      w_state = ST_STOPPED;
    end else if (r_pend) begin
      w_state = ST_RUN_PENDING;
    end else begin
      w_state = ST_RUNNING;
    end
  end

  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_div_nxt      = r_div_reg;
    w_pend_val_nxt = r_pend_val;
    w_pend_nxt     = r_pend;
    w_tick_nxt     = 1'b0;
    case (w_state)
      ST_STOPPED: begin
        if (r_pend) begin
          w_div_nxt  = r_pend_val;
          w_cnt_nxt  = r_pend_val;
          w_pend_nxt = 1'b0;
        end else if (w_accept) begin
          w_div_nxt = div_value;
          w_cnt_nxt = div_value;
        end
      end
      ST_RUNNING: begin
        if (w_cnt_zero) begin
          w_tick_nxt = 1'b1;
          if (w_accept) begin
            w_div_nxt = div_value;
            w_cnt_nxt = div_value;
          end else begin
            w_cnt_nxt = r_div_reg;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          // Mid-period load is parked so the current period finishes unchanged.
          if (w_accept) begin
            w_pend_val_nxt = div_value;
            w_pend_nxt     = 1'b1;
          end
        end
      end
      ST_RUN_PENDING: begin
        if (w_cnt_zero) begin
          w_tick_nxt = 1'b1;
          w_div_nxt  = r_pend_val;
          w_cnt_nxt  = r_pend_val;
          w_pend_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  always_ff @(posedge cin) begin
    if (reset) begin
      r_cnt      <= L_DIV_RESET;
      r_div_reg  <= L_DIV_RESET;
      r_pend_val <= '0;
      r_pend     <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_div_reg  <= w_div_nxt;
      r_pend_val <= w_pend_val_nxt;
      r_pend     <= w_pend_nxt;
      r_tick     <= w_tick_nxt;
    end
  end

  always_comb begin
    div_ready   = ~r_pend;
    tick        = r_tick;
    o_dbg_state = w_state;
  end

  tick_prescaler #(
    .N_TAPS (N_TAPS)
  ) u_tick_prescaler (
    .cin     (cin),
    .reset   (reset),
    .tick_en (w_tick_nxt),
`ifdef CLK_EN_LEVEL_OUT_EN
    .tap_lvl (tap_lvl),
`endif
    .tap_stb (tap_stb)
  );

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed self-checking bench for clk_enable_gen (default parameters).
// Level outputs are checked when CLK_EN_LEVEL_OUT_EN is defined.
module tb_clk_enable_gen;
  import clk_pkg::*;

  localparam int CNT_W  = 16;
  localparam int N_TAPS = 8;

  logic              cin;
  logic              reset;
  logic              run;
  logic              div_load;
  logic [CNT_W-1:0]  div_value;
  logic              div_ready;
  logic              tick;
  logic [N_TAPS-1:0] tap_stb;
  logic [1:0]        o_dbg_state;
`ifdef CLK_EN_LEVEL_OUT_EN
  logic [N_TAPS-1:0] tap_lvl;
`endif

  int n_tests;
  int n_fail;

  clk_enable_gen #(
    .CNT_W     (CNT_W),
    .N_TAPS    (N_TAPS),
    .DIV_RESET (1)
  ) dut (
    .cin         (cin),
    .reset       (reset),
    .run         (run),
    .div_load    (div_load),
    .div_value   (div_value),
    .div_ready   (div_ready),
    .tick        (tick),
    .tap_stb     (tap_stb),
`ifdef CLK_EN_LEVEL_OUT_EN
    .tap_lvl     (tap_lvl),
`endif
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset block
  initial cin = 1'b0;
  always #5 cin = ~cin;

  task automatic step();
    @(posedge cin);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Taps expected on the t-th tick after reset (t counts from 1).
  function automatic logic [N_TAPS-1:0] exp_taps(input int t);
    logic [N_TAPS-1:0] v;
    v = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      v[k] = ((t % (2 << k)) == 0);
    end
    return v;
  endfunction

  task automatic load_stopped(input logic [CNT_W-1:0] val);
    run       = 1'b0;
    div_load  = 1'b1;
    div_value = val;
    step();
    div_load  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_tick got %b exp 0", tick);
    end
    n_tests++;
    if (tap_stb !== '0) begin
      n_fail++; $display("FAIL reset_tap_stb got %h exp 00", tap_stb);
    end
    n_tests++;
    if (div_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_div_ready got %b exp 1", div_ready);
    end
    n_tests++;
    if (o_dbg_state !== 2'(ST_STOPPED)) begin
      n_fail++; $display("FAIL reset_state got %0d exp %0d", o_dbg_state, ST_STOPPED);
    end
`ifdef CLK_EN_LEVEL_OUT_EN
    n_tests++;
    if (tap_lvl !== '0) begin
      n_fail++; $display("FAIL reset_tap_lvl got %h exp 00", tap_lvl);
    end
`endif
  endtask

  task automatic test_default_run();
    int                t;
    logic              exp_tick;
    logic [N_TAPS-1:0] exp_stb;
    logic [N_TAPS-1:0] exp_lvl;
    do_reset();
    run     = 1'b1;
    t       = 0;
    exp_lvl = '0;
    for (int e = 1; e <= 64; e++) begin
      step();
      exp_tick = (e % 2 == 0);
      if (exp_tick) t++;
      exp_stb = exp_tick ? exp_taps(t) : '0;
      exp_lvl = exp_lvl ^ exp_stb;
      n_tests++;
      if (tick !== exp_tick) begin
        n_fail++; $display("FAIL default_tick edge %0d got %b exp %b", e, tick, exp_tick);
      end
      n_tests++;
      if (tap_stb !== exp_stb) begin
        n_fail++; $display("FAIL default_tap_stb edge %0d got %h exp %h", e, tap_stb, exp_stb);
      end
      n_tests++;
      if (div_ready !== 1'b1) begin
        n_fail++; $display("FAIL default_div_ready edge %0d got %b exp 1", e, div_ready);
      end
`ifdef CLK_EN_LEVEL_OUT_EN
      n_tests++;
      if (tap_lvl !== exp_lvl) begin
        n_fail++; $display("FAIL default_tap_lvl edge %0d got %h exp %h", e, tap_lvl, exp_lvl);
      end
`endif
    end
    run = 1'b0;
  endtask

  task automatic test_load_stopped();
    int                t;
    logic              exp_tick;
    logic [N_TAPS-1:0] exp_stb;
    do_reset();
    load_stopped(16'd3);
    n_tests++;
    if (div_ready !== 1'b1 || tick !== 1'b0) begin
      n_fail++; $display("FAIL stopped_load ready/tick got %b/%b exp 1/0", div_ready, tick);
    end
    run = 1'b1;
    t   = 0;
    for (int e = 1; e <= 40; e++) begin
      step();
      exp_tick = (e % 4 == 0);
      if (exp_tick) t++;
      exp_stb = exp_tick ? exp_taps(t) : '0;
      n_tests++;
      if (tick !== exp_tick) begin
        n_fail++; $display("FAIL stopped_load_tick edge %0d got %b exp %b", e, tick, exp_tick);
      end
      n_tests++;
      if (tap_stb !== exp_stb) begin
        n_fail++; $display("FAIL stopped_load_tap_stb edge %0d got %h exp %h", e, tap_stb, exp_stb);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_pending_load();
    int                t;
    logic              exp_tick;
    logic [N_TAPS-1:0] exp_stb;
    do_reset();
    load_stopped(16'd3);
    run = 1'b1;
    step();
    div_load  = 1'b1;
    div_value = 16'd1;
    step();
    n_tests++;
    if (div_ready !== 1'b0 || o_dbg_state !== 2'(ST_RUN_PENDING)) begin
      n_fail++; $display("FAIL pend_accept ready/state got %b/%0d exp 0/%0d", div_ready, o_dbg_state, ST_RUN_PENDING);
    end
    div_value = 16'd0;
    step();
    n_tests++;
    if (div_ready !== 1'b0 || tick !== 1'b0) begin
      n_fail++; $display("FAIL pend_hold ready/tick got %b/%b exp 0/0", div_ready, tick);
    end
    div_load = 1'b0;
    step();
    n_tests++;
    if (tick !== 1'b1 || div_ready !== 1'b1) begin
      n_fail++; $display("FAIL pend_reload tick/ready got %b/%b exp 1/1", tick, div_ready);
    end
    t = 1;
    for (int e = 5; e <= 24; e++) begin
      step();
      exp_tick = (e % 2 == 0);
      if (exp_tick) t++;
      exp_stb = exp_tick ? exp_taps(t) : '0;
      n_tests++;
      if (tick !== exp_tick) begin
        n_fail++; $display("FAIL pend_new_period_tick edge %0d got %b exp %b", e, tick, exp_tick);
      end
      n_tests++;
      if (tap_stb !== exp_stb || div_ready !== 1'b1) begin
        n_fail++; $display("FAIL pend_new_period stb/ready edge %0d got %h/%b exp %h/1", e, tap_stb, div_ready, exp_stb);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_bypass();
    int t;
    do_reset();
    load_stopped(16'd3);
    run = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      n_tests++;
      if (tick !== 1'b0) begin
        n_fail++; $display("FAIL bypass_pre_tick edge %0d got %b exp 0", e, tick);
      end
    end
    div_load  = 1'b1;
    div_value = 16'd0;
    step();
    div_load = 1'b0;
    n_tests++;
    if (tick !== 1'b1 || div_ready !== 1'b1) begin
      n_fail++; $display("FAIL bypass_edge tick/ready got %b/%b exp 1/1", tick, div_ready);
    end
    t = 1;
    for (int e = 5; e <= 20; e++) begin
      step();
      t++;
      n_tests++;
      if (tick !== 1'b1 || div_ready !== 1'b1) begin
        n_fail++; $display("FAIL bypass_tick/ready edge %0d got %b/%b exp 1/1", e, tick, div_ready);
      end
      n_tests++;
      if (tap_stb !== exp_taps(t)) begin
        n_fail++; $display("FAIL bypass_tap_stb edge %0d got %h exp %h", e, tap_stb, exp_taps(t));
      end
    end
    run = 1'b0;
  endtask

  task automatic test_run_stop_wrap();
    int                t;
    int                n_top;
    logic              exp_tick;
    logic [N_TAPS-1:0] exp_stb;
    do_reset();
    load_stopped(16'd3);
    run = 1'b1;
    step();
    run = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      n_tests++;
      if (tick !== 1'b0 || tap_stb !== '0 || o_dbg_state !== 2'(ST_STOPPED)) begin
        n_fail++; $display("FAIL stopped_quiet edge %0d tick/stb/state got %b/%h/%0d exp 0/00/0", e, tick, tap_stb, o_dbg_state);
      end
    end
    run   = 1'b1;
    t     = 0;
    n_top = 0;
    for (int e = 1; e <= 3 + 4 * 520; e++) begin
      step();
      exp_tick = (e >= 3) && ((e - 3) % 4 == 0);
      if (exp_tick) t++;
      exp_stb = exp_tick ? exp_taps(t) : '0;
      if (tap_stb[N_TAPS-1] === 1'b1) n_top++;
      n_tests++;
      if (tick !== exp_tick) begin
        n_fail++; $display("FAIL resume_tick edge %0d got %b exp %b", e, tick, exp_tick);
      end
      n_tests++;
      if (tap_stb !== exp_stb) begin
        n_fail++; $display("FAIL resume_tap_stb edge %0d got %h exp %h", e, tap_stb, exp_stb);
      end
    end
    n_tests++;
    if (n_top !== 2) begin
      n_fail++; $display("FAIL wrap_top_tap_count got %0d exp 2", n_top);
    end
    run = 1'b0;
  endtask

  task automatic test_reset_pending();
    int                t;
    logic              exp_tick;
    logic [N_TAPS-1:0] exp_stb;
    do_reset();
    load_stopped(16'd3);
    run = 1'b1;
    step();
    div_load  = 1'b1;
    div_value = 16'd5;
    step();
    div_load = 1'b0;
    n_tests++;
    if (div_ready !== 1'b0 || o_dbg_state !== 2'(ST_RUN_PENDING)) begin
      n_fail++; $display("FAIL rstpend_setup ready/state got %b/%0d exp 0/%0d", div_ready, o_dbg_state, ST_RUN_PENDING);
    end
    reset = 1'b1;
    step();
    n_tests++;
    if (div_ready !== 1'b1 || tick !== 1'b0 || tap_stb !== '0) begin
      n_fail++; $display("FAIL rstpend_outputs ready/tick/stb got %b/%b/%h exp 1/0/00", div_ready, tick, tap_stb);
    end
`ifdef CLK_EN_LEVEL_OUT_EN
    n_tests++;
    if (tap_lvl !== '0) begin
      n_fail++; $display("FAIL rstpend_tap_lvl got %h exp 00", tap_lvl);
    end
`endif
    reset = 1'b0;
    t     = 0;
    for (int e = 1; e <= 16; e++) begin
      step();
      exp_tick = (e % 2 == 0);
      if (exp_tick) t++;
      exp_stb = exp_tick ? exp_taps(t) : '0;
      n_tests++;
      if (tick !== exp_tick || div_ready !== 1'b1) begin
        n_fail++; $display("FAIL rstpend_tick/ready edge %0d got %b/%b exp %b/1", e, tick, div_ready, exp_tick);
      end
      n_tests++;
      if (tap_stb !== exp_stb) begin
        n_fail++; $display("FAIL rstpend_tap_stb edge %0d got %h exp %h", e, tap_stb, exp_stb);
      end
    end
    run = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    run       = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    test_reset();
    test_default_run();
    test_load_stopped();
    test_pending_load();
    test_bypass();
    test_run_stop_wrap();
    test_reset_pending();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
